imm_encoder: RTL



---
 rtl/imm_encoder_pkg.sv | 66 ++++++
 rtl/imm_encoder_pack.sv | 56 +++++
 rtl/imm_encoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// ----------------------------------------------------------------------------
// imm_encoder_pkg
// Shared definitions for the immediate encoder:
//   - ImmSrc encodings (I, S, B, J)
//   - per-format masks of the instruction bits that hold immediate fields
//   - per-format immediate widths used by the range check
//   - helper functions that select a mask or width, and that truncate an
//     immediate to exactly what its format can represent
// ----------------------------------------------------------------------------
package imm_encoder_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
    localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J  = 32'hFFFF_F000;

    localparam int unsigned BOUND_I = 12;
    localparam int unsigned BOUND_S = 12;
    localparam int unsigned BOUND_B = 13;
    localparam int unsigned BOUND_J = 21;

    // Instruction bits owned by the immediate of the given format.
    function automatic logic [31:0] fieldMask(input logic [1:0] src);
        logic [31:0] m;
        case (src)
            IMM_I:   m = MASK_I;
            IMM_S:   m = MASK_SB;
            IMM_B:   m = MASK_SB;
            default: m = MASK_J;
        endcase
        return m;
    endfunction

    // Number of signed bits the format can carry (bit 0 included for B/J).
    function automatic int unsigned immBound(input logic [1:0] src);
        int unsigned b;
        case (src)
            IMM_I:   b = BOUND_I;
            IMM_S:   b = BOUND_S;
            IMM_B:   b = BOUND_B;
            default: b = BOUND_J;
        endcase
        return b;
    endfunction

    // Sign-extend the low immBound bits; B/J cannot encode bit 0, so it is
    // forced to zero to match what a decoder would reconstruct.
    function automatic logic [31:0] truncImm(input logic [31:0] imm,
                                             input logic [1:0]  src);
        logic [31:0] shifted;
        logic [31:0] r;
        int unsigned sh;
        sh      = 32 - immBound(src);
        shifted = imm << sh;
        r       = $unsigned($signed(shifted) >>> sh);
        if (src == IMM_B || src == IMM_J) begin
            r[0] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// ----------------------------------------------------------------------------
// imm_pack
// Combinational mask-and-scatter of a signed immediate into a base
// instruction word, plus the check that the immediate fits its format.
// Ports:
//   i_base      base instruction, immediate bits are ignored
//   i_imm       signed immediate (byte offset for B/J)
//   i_immSrc    format select: 00 I, 01 S, 10 B, 11 J
//   o_instr     base word with the format's immediate fields replaced
//   o_rangeErr  1 when the immediate cannot be represented by the format
// ----------------------------------------------------------------------------
module imm_pack
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_base,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [1:0]            i_immSrc,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_rangeErr
);

    logic [DATA_WIDTH-1:0]        w_field;
    logic signed [DATA_WIDTH-1:0] w_hi;
    logic                         w_fits;

    // Scatter the immediate bits to the positions the decoder gathers them
    // from; every bit outside the format's fields stays zero so the OR
    // below only touches cleared positions.
    always_comb begin
        w_field = '0;
        case (i_immSrc)
            IMM_I:   w_field = {i_imm[11:0], 20'b0};
            IMM_S:   w_field = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
            IMM_B:   w_field = {i_imm[12], i_imm[10:5], 13'b0,
                                i_imm[4:1], i_imm[11], 7'b0};
            default: w_field = {i_imm[20], i_imm[10:1], i_imm[11],
                                i_imm[19:12], 12'b0};
        endcase
    end

    // Shifting right by (width-1) leaves only the sign-extension bits; the
    // value fits exactly when those are all zeros or all ones.
    always_comb begin
        w_hi   = $signed(i_imm) >>> (immBound(i_immSrc) - 1);
        w_fits = (w_hi == '0) || (&w_hi);
        if ((i_immSrc == IMM_B || i_immSrc == IMM_J) && i_imm[0]) begin
            w_fits = 1'b0;
        end
    end

    assign o_instr    = (i_base & ~fieldMask(i_immSrc)) | w_field;
    assign o_rangeErr = !w_fits;

endmodule

// File: rtl/imm_encoder.sv
// ----------------------------------------------------------------------------
// imm_encoder
// Two-stage valid/ready pipeline that packs signed immediates into I/S/B/J
// instruction words for the instruction-memory program loader. Each emitted
// word is stamped with a sequential byte address, and immediates that do not
// fit their format are flagged and counted.
// Optional build macro IMM_ENCODER_ROUNDTRIP_CHECK_EN adds out_rt_mismatch,
// which decodes the emitted word back and compares it to the truncated input.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready is combinational from out_ready
//   in_base         base instruction word
//   in_imm          signed immediate
//   in_ImmSrc       format select: 00 I, 01 S, 10 B, 11 J
//   out_valid/ready output handshake
//   out_instr       packed instruction
//   out_addr        loader byte address of out_instr
//   out_range_err   immediate was out of range for its format
//   err_count       saturating count of emitted range errors
//   out_rt_mismatch (optional) round-trip decode disagreed with input
// ----------------------------------------------------------------------------
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IMM_WIDTH  = 2,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_base,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [IMM_WIDTH-1:0]  in_ImmSrc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_range_err,
    output logic [CNT_WIDTH-1:0]  err_count
`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
    ,
    output logic                  out_rt_mismatch
`endif
);

    logic                  w_s1Load;
    logic                  w_s2Load;
    logic                  w_handshake;
    logic [DATA_WIDTH-1:0] w_packed;
    logic                  w_rangeErr;

    logic                  r_s1Valid;
    logic [DATA_WIDTH-1:0] r_s1Instr;
    logic                  r_s1Err;
    logic                  r_s2Valid;
    logic [DATA_WIDTH-1:0] r_s2Instr;
    logic                  r_s2Err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_errCount;

`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
    logic [DATA_WIDTH-1:0] r_s1Imm;
    logic [1:0]            r_s1Src;
    logic [DATA_WIDTH-1:0] r_s2Trunc;
    logic [1:0]            r_s2Src;
`endif

    imm_pack #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pack (
        .i_base    (in_base),
        .i_imm     (in_imm),
        .i_immSrc  (in_ImmSrc),
        .o_instr   (w_packed),
        .o_rangeErr(w_rangeErr)
    );

    // A stage may load when it is empty or when its contents move on in the
    // same cycle, which gives full throughput with no skid buffer.
    assign w_s2Load    = !r_s2Valid || out_ready;
    assign w_s1Load    = !r_s1Valid || w_s2Load;
    assign w_handshake = r_s2Valid && out_ready;
    assign in_ready    = w_s1Load;

    // Stage 1 captures the already packed word and its range flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Instr <= '0;
            r_s1Err   <= 1'b0;
        end else if (w_s1Load) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1Instr <= w_packed;
                r_s1Err   <= w_rangeErr;
            end
        end
    end

    // Stage 2 holds the word presented on the outputs; it only changes when
    // the current word is accepted or the stage is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Instr <= '0;
            r_s2Err   <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Instr <= r_s1Instr;
                r_s2Err   <= r_s1Err;
            end
        end
    end

    // Address and error count advance once per word actually delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= BASE_ADDR;
            r_errCount <= '0;
        end else if (w_handshake) begin
            r_addr <= r_addr + ADDR_WIDTH'(4);
            if (r_s2Err && (r_errCount != {CNT_WIDTH{1'b1}})) begin
                r_errCount <= r_errCount + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid     = r_s2Valid;
    assign out_instr     = r_s2Instr;
    assign out_range_err = r_s2Err;
    assign out_addr      = r_addr;
    assign err_count     = r_errCount;

`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
    // Gather the immediate back out of a packed word, exactly as decode does.
    function automatic logic [31:0] decodeImm(input logic [31:0] ins,
                                              input logic [1:0]  src);
        logic [31:0] v;
        case (src)
            IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                          ins[11:8], 1'b0};
            default: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                          ins[30:21], 1'b0};
        endcase
        return v;
    endfunction

    // The raw immediate and format ride along stage 1; stage 2 keeps only
    // the truncated value that the decoded word must reproduce.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Imm   <= '0;
            r_s1Src   <= IMM_I;
            r_s2Trunc <= '0;
            r_s2Src   <= IMM_I;
        end else begin
            if (w_s1Load && in_valid) begin
                r_s1Imm <= in_imm;
                r_s1Src <= in_ImmSrc;
            end
            if (w_s2Load && r_s1Valid) begin
                r_s2Trunc <= truncImm(r_s1Imm, r_s1Src);
                r_s2Src   <= r_s1Src;
            end
        end
    end

    assign out_rt_mismatch = r_s2Valid &&
                             (decodeImm(r_s2Instr, r_s2Src) != r_s2Trunc);

    a_rtConsistent : assert property (@(posedge clk) disable iff (rst)
        !(out_valid && out_rt_mismatch && !out_range_err));
`endif

endmodule
